// File: rtl/ahb_csr_timer.sv
// CSR target on the AHB-Lite slave's T_* access port. Provides ID/CTRL/LOAD/COUNT/STATUS/SCRATCH
// registers that control a prescaled down-counter timer with expiry status and a level interrupt.
module ahb_csr_timer #(
   parameter int          ADDR_W   = 8,
   parameter int          CNT_W    = 32,
   parameter logic [31:0] ID_VALUE = 32'h5449_4D31
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic [ADDR_W-1:0] T_ADDR,
   input  logic              T_WREN,
   input  logic [31:0]       T_WDATA,
   input  logic              T_RDEN,
   input  logic [2:0]        T_SIZE,
   output logic [31:0]       T_RDATA,
   output logic              irq
);

   localparam int IDX_W = ADDR_W - 2;
   localparam logic [IDX_W-1:0] IDX_ID      = IDX_W'(0);
   localparam logic [IDX_W-1:0] IDX_CTRL    = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LOAD    = IDX_W'(2);
   localparam logic [IDX_W-1:0] IDX_COUNT   = IDX_W'(3);
   localparam logic [IDX_W-1:0] IDX_STATUS  = IDX_W'(4);
   localparam logic [IDX_W-1:0] IDX_SCRATCH = IDX_W'(5);

   // architectural state
   logic             en_reg,       en_next;
   logic             auto_reg,     auto_next;
   logic             irq_en_reg,   irq_en_next;
   logic [7:0]       prescale_reg, prescale_next;
   logic [CNT_W-1:0] load_reg,     load_next;
   logic [CNT_W-1:0] count_reg,    count_next;
   logic             expired_reg,  expired_next;
   logic             overrun_reg,  overrun_next;
   logic [31:0]      scratch_reg,  scratch_next;
   logic [7:0]       presc_cnt_reg, presc_next;
   logic [31:0]      rdata_reg,    rdata_next;

   logic [IDX_W-1:0] reg_idx;
   logic [3:0]       lane_mask;
   logic [31:0]      bit_mask;
   logic             wr_ctrl, wr_load, wr_status, wr_scratch;
   logic [31:0]      ctrl_word, status_word;
   logic [31:0]      ctrl_merge, load_merge, scratch_merge, w1c_bits;
   logic [31:0]      rd_mux;
   logic             presc_hit, count_zero, tick, expire;
   logic             unused_bits;

   assign reg_idx = T_ADDR[ADDR_W-1:2];

   always_comb begin
      lane_mask = 4'b1111;
      if (T_SIZE == 3'd0) begin
         lane_mask = 4'b0001 << T_ADDR[1:0];
      end else if (T_SIZE == 3'd1) begin
         lane_mask = T_ADDR[1] ? 4'b1100 : 4'b0011;
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign bit_mask[8*gi +: 8] = {8{lane_mask[gi]}};
      end
   endgenerate

   assign wr_ctrl    = T_WREN && (reg_idx == IDX_CTRL);
   assign wr_load    = T_WREN && (reg_idx == IDX_LOAD);
   assign wr_status  = T_WREN && (reg_idx == IDX_STATUS);
   assign wr_scratch = T_WREN && (reg_idx == IDX_SCRATCH);

   assign ctrl_word   = {16'h0000, prescale_reg, 5'b00000, irq_en_reg, auto_reg, en_reg};
   assign status_word = {30'd0, overrun_reg, expired_reg};

   // Byte-lane merge: lanes outside the access keep their current contents.
   assign ctrl_merge    = (ctrl_word     & ~bit_mask) | (T_WDATA & bit_mask);
   assign load_merge    = (32'(load_reg) & ~bit_mask) | (T_WDATA & bit_mask);
   assign scratch_merge = (scratch_reg   & ~bit_mask) | (T_WDATA & bit_mask);
   assign w1c_bits      = T_WDATA & bit_mask;

   assign unused_bits = ^{ctrl_merge[31:16], ctrl_merge[7:3], w1c_bits[31:2], load_merge};

   // A LOAD write takes priority over a tick on the same edge: no decrement, no expiry.
   assign presc_hit  = (presc_cnt_reg == prescale_reg);
   assign count_zero = (count_reg == '0);
   assign tick       = en_reg && presc_hit && !wr_load;
   assign expire     = tick && count_zero;

   always_comb begin
      en_next       = en_reg;
      auto_next     = auto_reg;
      irq_en_next   = irq_en_reg;
      prescale_next = prescale_reg;
      load_next     = load_reg;
      count_next    = count_reg;
      scratch_next  = scratch_reg;
      presc_next    = presc_cnt_reg;
      // hardware set beats a simultaneous write-one-to-clear
      expired_next  = (expired_reg & ~(wr_status & w1c_bits[0])) | expire;
      overrun_next  = (overrun_reg & ~(wr_status & w1c_bits[1])) | (expire & expired_reg);

      if (en_reg) begin
         presc_next = presc_hit ? 8'd0 : presc_cnt_reg + 8'd1;
      end

      if (tick) begin
         if (!count_zero) begin
            count_next = count_reg - CNT_W'(1);
         end else if (auto_reg) begin
            count_next = load_reg;
         end else begin
            en_next = 1'b0;
         end
      end

      if (wr_ctrl) begin
         en_next       = ctrl_merge[0];
         auto_next     = ctrl_merge[1];
         irq_en_next   = ctrl_merge[2];
         prescale_next = ctrl_merge[15:8];
         if (!en_reg && ctrl_merge[0]) begin
            presc_next = 8'd0;
         end
      end

      if (wr_load) begin
         load_next  = load_merge[CNT_W-1:0];
         count_next = load_merge[CNT_W-1:0];
         presc_next = 8'd0;
      end

      if (wr_scratch) begin
         scratch_next = scratch_merge;
      end
   end

   always_comb begin
      case (reg_idx)
         IDX_ID:      rd_mux = ID_VALUE;
         IDX_CTRL:    rd_mux = ctrl_word;
         IDX_LOAD:    rd_mux = 32'(load_reg);
         IDX_COUNT:   rd_mux = 32'(count_reg);
         IDX_STATUS:  rd_mux = status_word;
         IDX_SCRATCH: rd_mux = scratch_reg;
         default:     rd_mux = 32'd0;
      endcase
   end

   // Read data reflects register state before any write on the same edge.
   assign rdata_next = T_RDEN ? rd_mux : rdata_reg;

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         en_reg        <= 1'b0;
         auto_reg      <= 1'b0;
         irq_en_reg    <= 1'b0;
         prescale_reg  <= 8'd0;
         load_reg      <= '0;
         count_reg     <= '0;
         expired_reg   <= 1'b0;
         overrun_reg   <= 1'b0;
         scratch_reg   <= 32'd0;
         presc_cnt_reg <= 8'd0;
         rdata_reg     <= 32'd0;
      end else begin
         en_reg        <= en_next;
         auto_reg      <= auto_next;
         irq_en_reg    <= irq_en_next;
         prescale_reg  <= prescale_next;
         load_reg      <= load_next;
         count_reg     <= count_next;
         expired_reg   <= expired_next;
         overrun_reg   <= overrun_next;
         scratch_reg   <= scratch_next;
         presc_cnt_reg <= presc_next;
         rdata_reg     <= rdata_next;
      end
   end

   assign T_RDATA = rdata_reg;
   assign irq     = expired_reg & irq_en_reg;

endmodule

// File: tb/tb_ahb_csr_timer.sv
// Bench for ahb_csr_timer: directed scenarios plus randomized traffic checked against
// a word-level behavioural model of the register map and timer.
module tb_ahb_csr_timer;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic [7:0]  T_ADDR;
   logic        T_WREN;
   logic [31:0] T_WDATA;
   logic        T_RDEN;
   logic [2:0]  T_SIZE;
   logic [31:0] T_RDATA;
   logic        irq;

   int n_cmp = 0;
   int n_bad = 0;

   // behavioural model state (CTRL kept as its readable 32-bit image)
   logic [31:0] m_ctrl, m_load, m_count, m_status, m_scratch, m_rdata;
   logic [7:0]  m_presc;

   always #5 HCLK = ~HCLK;

   ahb_csr_timer dut (
      .HCLK    (HCLK),
      .HRESET  (HRESET),
      .T_ADDR  (T_ADDR),
      .T_WREN  (T_WREN),
      .T_WDATA (T_WDATA),
      .T_RDEN  (T_RDEN),
      .T_SIZE  (T_SIZE),
      .T_RDATA (T_RDATA),
      .irq     (irq)
   );

   function automatic logic m_irq();
      return m_status[0] & m_ctrl[2];
   endfunction

   task automatic model_clear();
      m_ctrl = 0; m_load = 0; m_count = 0; m_status = 0;
      m_scratch = 0; m_rdata = 0; m_presc = 0;
   endtask

   task automatic do_reset();
      T_WREN = 0; T_RDEN = 0; HRESET = 1;
      @(posedge HCLK); #1;
      HRESET = 0;
      model_clear();
   endtask

   // One bus cycle: model advances alongside the DUT edge.
   task automatic step(input logic wr, input logic rd, input logic [7:0] addr,
                       input logic [2:0] size, input logic [31:0] wdata);
      logic [31:0] bm, rdv, clr, setb, n_ctrl, n_load, n_count, n_scratch;
      logic [7:0]  n_presc;
      logic        en, tick, on;
      int          idx;
      bm = 0;
      for (int k = 0; k < 4; k++) begin
         if (size == 3'd0)      on = (int'(addr[1:0]) == k);
         else if (size == 3'd1) on = ((k / 2) == int'(addr[1]));
         else                   on = 1'b1;
         if (on) bm[8*k +: 8] = 8'hFF;
      end
      idx = int'(addr >> 2);
      case (idx)
         0: rdv = 32'h5449_4D31;
         1: rdv = m_ctrl;
         2: rdv = m_load;
         3: rdv = m_count;
         4: rdv = m_status;
         5: rdv = m_scratch;
         default: rdv = 0;
      endcase
      en = m_ctrl[0];
      tick = en && (m_presc == m_ctrl[15:8]) && !(wr && idx == 2);
      n_ctrl = m_ctrl; n_load = m_load; n_count = m_count; n_scratch = m_scratch;
      n_presc = m_presc; clr = 0; setb = 0;
      if (en) n_presc = (m_presc == m_ctrl[15:8]) ? 8'd0 : m_presc + 8'd1;
      if (tick) begin
         if (m_count != 0) n_count = m_count - 32'd1;
         else begin
            setb = m_status[0] ? 32'd3 : 32'd1;
            if (m_ctrl[1]) n_count = m_load;
            else n_ctrl[0] = 1'b0;
         end
      end
      if (wr) begin
         case (idx)
            1: begin
               n_ctrl = ((m_ctrl & ~bm) | (wdata & bm)) & 32'h0000_FF07;
               if (!en && n_ctrl[0]) n_presc = 0;
            end
            2: begin
               n_load = (m_load & ~bm) | (wdata & bm);
               n_count = n_load;
               n_presc = 0;
            end
            4: clr = wdata & bm & 32'h3;
            5: n_scratch = (m_scratch & ~bm) | (wdata & bm);
            default: ;
         endcase
      end
      if (rd) m_rdata = rdv;
      m_ctrl = n_ctrl; m_load = n_load; m_count = n_count; m_scratch = n_scratch;
      m_presc = n_presc; m_status = (m_status & ~clr) | setb;
      T_ADDR = addr; T_WREN = wr; T_RDEN = rd; T_SIZE = size; T_WDATA = wdata;
      @(posedge HCLK); #1;
      T_WREN = 0; T_RDEN = 0;
   endtask

   task automatic wr_reg(input logic [7:0] a, input logic [2:0] s, input logic [31:0] d);
      step(1'b1, 1'b0, a, s, d);
   endtask

   task automatic rd_reg(input logic [7:0] a);
      step(1'b0, 1'b1, a, 3'd2, 32'd0);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 8'h00, 3'd2, 32'd0);
   endtask

   task automatic test_reset();
      HRESET = 1; T_ADDR = 0; T_WREN = 0; T_RDEN = 0; T_SIZE = 2; T_WDATA = 0;
      @(posedge HCLK); #1;
      do_reset();
      n_cmp++;
      if (T_RDATA !== 32'd0 || irq !== 1'b0) begin
         n_bad++; $display("FAIL reset_out: rdata=%h irq=%b expected 0/0", T_RDATA, irq);
      end
      rd_reg(8'h00);
      n_cmp++;
      if (T_RDATA !== 32'h5449_4D31) begin
         n_bad++; $display("FAIL reset_id: got %h expected 54494d31", T_RDATA);
      end
      rd_reg(8'h0C);
      n_cmp++;
      if (T_RDATA !== 32'd0 || irq !== 1'b0) begin
         n_bad++; $display("FAIL reset_count: rdata=%h irq=%b expected 0/0", T_RDATA, irq);
      end
   endtask

   task automatic test_scratch_lanes();
      wr_reg(8'h14, 3'd2, 32'hA5A5_A5A5);
      wr_reg(8'h15, 3'd0, 32'h0000_3C00);
      rd_reg(8'h14);
      n_cmp++;
      if (T_RDATA !== 32'hA5A5_3CA5) begin
         n_bad++; $display("FAIL scratch_byte: got %h expected a5a53ca5", T_RDATA);
      end
      wr_reg(8'h16, 3'd1, 32'h1234_FFFF);
      rd_reg(8'h14);
      n_cmp++;
      if (T_RDATA !== 32'h1234_3CA5) begin
         n_bad++; $display("FAIL scratch_half: got %h expected 12343ca5", T_RDATA);
      end
      wr_reg(8'h20, 3'd2, 32'hFFFF_FFFF);
      rd_reg(8'h20);
      n_cmp++;
      if (T_RDATA !== 32'd0) begin
         n_bad++; $display("FAIL unmapped_read: got %h expected 0", T_RDATA);
      end
   endtask

   task automatic test_oneshot();
      logic [31:0] exp_cnt [4];
      exp_cnt = '{32'd3, 32'd2, 32'd1, 32'd0};
      wr_reg(8'h08, 3'd2, 32'd3);
      wr_reg(8'h04, 3'd2, 32'h0000_0005);
      for (int i = 0; i < 4; i++) begin
         rd_reg(8'h0C);
         n_cmp++;
         if (T_RDATA !== exp_cnt[i]) begin
            n_bad++; $display("FAIL oneshot_count[%0d]: got %h expected %h", i, T_RDATA, exp_cnt[i]);
         end
      end
      n_cmp++;
      if (irq !== 1'b1) begin
         n_bad++; $display("FAIL oneshot_irq: got %b expected 1", irq);
      end
      rd_reg(8'h04);
      n_cmp++;
      if (T_RDATA !== 32'h0000_0004) begin
         n_bad++; $display("FAIL oneshot_en_clear: ctrl got %h expected 00000004", T_RDATA);
      end
      idle(); idle();
      rd_reg(8'h0C);
      n_cmp++;
      if (T_RDATA !== 32'd0) begin
         n_bad++; $display("FAIL oneshot_hold: count got %h expected 0", T_RDATA);
      end
      rd_reg(8'h10);
      n_cmp++;
      if (T_RDATA !== 32'd1) begin
         n_bad++; $display("FAIL oneshot_status: got %h expected 1", T_RDATA);
      end
      wr_reg(8'h10, 3'd2, 32'd3);
      rd_reg(8'h10);
      n_cmp++;
      if (T_RDATA !== 32'd0 || irq !== 1'b0) begin
         n_bad++; $display("FAIL oneshot_w1c: status=%h irq=%b expected 0/0", T_RDATA, irq);
      end
   endtask

   task automatic test_auto_reload();
      logic [31:0] exp_cnt [12];
      exp_cnt = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
      wr_reg(8'h08, 3'd2, 32'd1);
      wr_reg(8'h04, 3'd2, 32'h0000_0207);
      for (int i = 0; i < 12; i++) begin
         rd_reg(8'h0C);
         n_cmp++;
         if (T_RDATA !== exp_cnt[i]) begin
            n_bad++; $display("FAIL auto_count[%0d]: got %h expected %h", i, T_RDATA, exp_cnt[i]);
         end
      end
      rd_reg(8'h10);
      n_cmp++;
      if (T_RDATA !== 32'd3 || irq !== 1'b1) begin
         n_bad++; $display("FAIL auto_overrun: status=%h irq=%b expected 3/1", T_RDATA, irq);
      end
   endtask

   task automatic test_w1c_race();
      bit found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (m_ctrl[0] && m_presc == m_ctrl[15:8] && m_count == 0) begin
            wr_reg(8'h10, 3'd2, 32'd1);
            found = 1;
         end else begin
            idle();
         end
      end
      n_cmp++;
      if (!found) begin
         n_bad++; $display("FAIL w1c_race_timeout: no expiry tick within 20 cycles");
      end
      rd_reg(8'h10);
      n_cmp++;
      if (T_RDATA !== 32'd3) begin
         n_bad++; $display("FAIL w1c_race_setwins: status got %h expected 3", T_RDATA);
      end
      wr_reg(8'h04, 3'd2, 32'd0);
      wr_reg(8'h10, 3'd2, 32'd3);
      rd_reg(8'h10);
      n_cmp++;
      if (T_RDATA !== 32'd0 || irq !== 1'b0) begin
         n_bad++; $display("FAIL w1c_clear: status=%h irq=%b expected 0/0", T_RDATA, irq);
      end
   endtask

   task automatic test_back_to_back();
      wr_reg(8'h14, 3'd2, 32'h1111_1111);
      step(1'b1, 1'b1, 8'h14, 3'd2, 32'h2222_2222);
      n_cmp++;
      if (T_RDATA !== 32'h1111_1111) begin
         n_bad++; $display("FAIL rdwr_same_cycle: got %h expected 11111111", T_RDATA);
      end
      rd_reg(8'h14);
      n_cmp++;
      if (T_RDATA !== 32'h2222_2222) begin
         n_bad++; $display("FAIL rdwr_after: got %h expected 22222222", T_RDATA);
      end
      rd_reg(8'h00);
      n_cmp++;
      if (T_RDATA !== 32'h5449_4D31) begin
         n_bad++; $display("FAIL b2b_id: got %h expected 54494d31", T_RDATA);
      end
      idle();
      n_cmp++;
      if (T_RDATA !== 32'h5449_4D31) begin
         n_bad++; $display("FAIL rdata_hold: got %h expected 54494d31", T_RDATA);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] addrs [5];
      addrs = '{8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};
      wr_reg(8'h14, 3'd2, 32'hDEAD_BEEF);
      wr_reg(8'h08, 3'd2, 32'd1);
      wr_reg(8'h04, 3'd2, 32'h0000_0007);
      idle(); idle();
      rd_reg(8'h14);
      n_cmp++;
      if (irq !== 1'b1 || T_RDATA !== 32'hDEAD_BEEF) begin
         n_bad++; $display("FAIL midreset_pre: irq=%b rdata=%h expected 1/deadbeef", irq, T_RDATA);
      end
      do_reset();
      n_cmp++;
      if (T_RDATA !== 32'd0 || irq !== 1'b0) begin
         n_bad++; $display("FAIL midreset_out: rdata=%h irq=%b expected 0/0", T_RDATA, irq);
      end
      idle(); idle(); idle();
      for (int i = 0; i < 5; i++) begin
         rd_reg(addrs[i]);
         n_cmp++;
         if (T_RDATA !== 32'd0 || irq !== 1'b0) begin
            n_bad++; $display("FAIL midreset_reg[%h]: got %h irq=%b expected 0/0", addrs[i], T_RDATA, irq);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0]  a;
      logic [31:0] d;
      logic        w, r;
      int          op;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         op = int'($urandom_range(0, 9));
         a = 8'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
         d = $urandom;
         if ((a >> 2) == 8'd1) d = d & 32'hFFFF_03FF;
         if ((a >> 2) == 8'd2) d = d & 32'h0000_0007;
         w = (op < 4);
         r = (op >= 3 && op < 9);
         step(w, r, a, 3'($urandom_range(0, 3)), d);
         n_cmp++;
         if (T_RDATA !== m_rdata || irq !== m_irq()) begin
            n_bad++;
            $display("FAIL random[%0d] addr=%h wr=%b rd=%b: rdata=%h irq=%b expected %h/%b",
                     i, a, w, r, T_RDATA, irq, m_rdata, m_irq());
         end
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_scratch_lanes();
      test_oneshot();
      test_auto_reload();
      test_w1c_race();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
